mux2_arbiter: RTL and testbench
===============================

# mux2_arbiter

Round-robin arbiter and sequencer for the shared 2:1 datapath mux: two requesters (A, B) compete for one downstream port, and the block drives the mux select so the winning source owns the output for a whole burst. Transfers use a valid/ready handshake. A per-burst beat limit stops either source from holding the port indefinitely. It sits directly in front of the mux and owns its select line.

## Interface
- `WIDTH`, 8: data width of each source and of the output.
- `MAX_BEATS`, 16: maximum beats per grant (at least 1). Counter width is clog2(MAX_BEATS+1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `a_data`  in  WIDTH  source A payload.
- `a_valid`  in  1  A beat present.
- `a_last`  in  1  A beat ends its burst.
- `a_ready`  out  1  A beat accepted this cycle.
- `b_data`, `b_valid`, `b_last`  in  WIDTH/1/1  source B, same meaning as A.
- `b_ready`  out  1  B beat accepted this cycle.
- `out_data`  out  WIDTH  muxed payload.
- `out_valid`  out  1  output beat present.
- `out_last`  out  1  output beat ends the burst, either source last or forced.
- `out_ready`  in  1  downstream accepts.
- `sin`  out  1  registered mux select: 1 selects A, 0 selects B.
- `busy`  out  1  a grant is active.

## Operation
- States are IDLE, GNT_A and GNT_B. `sin` is 1 in GNT_A and 0 otherwise. `busy` is high in GNT_A and GNT_B.
- Datapath: out_data = (sin & a_data) | (~sin & b_data), bitwise, with no register.
- In IDLE: out_valid=0, out_last=0, a_ready=0, b_ready=0.
- In GNT_A:
  - out_valid=a_valid.
  - a_ready=out_ready.
  - b_ready=0.
  - out_last = a_last | (beat_cnt == MAX_BEATS-1).
- GNT_B mirrors GNT_A with the sources swapped.
- A beat transfers when out_valid & out_ready.
  - beat_cnt increments per transfer.
  - beat_cnt clears on grant change and on entry to IDLE.
- A burst ends on a transfer with out_last=1, whether from the source or forced by the limit.
- Priority pointer `ptr`:
  - 1 means A is favoured, 0 means B is favoured.
  - Reset value is 1.
  - At each burst end it points at the source that did not just finish.
- Transitions from IDLE:
  - a_valid & b_valid: go to GNT_A if ptr=1, else GNT_B.
  - Only a_valid: go to GNT_A.
  - Only b_valid: go to GNT_B.
  - Neither: stay in IDLE.
- Transitions at burst end in GNT_X:
  - Other source valid: go directly to its grant, with no bubble cycle.
  - Else X still valid: re-grant X.
  - Else: go to IDLE.
- A forced end (limit reached without source last) is treated exactly like a source last. The source continues in a later grant.
- A granted source dropping valid mid-burst does not release the grant. The block waits.
- Requests from the non-granted source are ignored until the burst ends.

## Timing
- Reset (rst high at a clock edge) forces:
  - state=IDLE, sin=0, ptr=1, beat_cnt=0.
  - All outputs are 0 on the following cycle, except out_data, which follows b_data.
- Reset mid-burst abandons the burst. No completion is signalled.
- Arbitration latency: a request arriving in IDLE is granted on the next edge. The first beat can transfer in cycle 2.
- Back-to-back bursts from alternating sources carry no idle cycle between them.
- The handshake is combinational from out_ready to a_ready/b_ready. There is no path from valid to ready.
- The select changes only on clock edges, never mid-cycle.

## Structure
- Shared package `mux_arb_pkg`:
  - State encoding: IDLE=2'd0, GNT_A=2'd1, GNT_B=2'd2.
  - Constants SEL_A=1'b1 and SEL_B=1'b0.
- One sub-module, `mux2`: the combinational 2:1 select (a, b, sin → f), instantiated WIDTH-wide. The arbiter FSM, pointer and beat counter stay in the top module.

## Test plan
- Reset check: hold rst 2 cycles with both valids high → sin=0, busy=0, out_valid=0, a_ready=b_ready=0. On release, first grant is A (ptr=1).
- Alternation: both sources send continuous 3-beat bursts (A data 0xA0–0xA2, B data 0xB0–0xB2), out_ready=1 → output sequence is A,A,A,B,B,B,A,… with no gap cycle; sin toggles each 3 beats.
- Limit: MAX_BEATS=4, A sends a 6-beat burst with B idle → out_last on beat 4 is forced high, A is re-granted next, and beats 5–6 follow; out_last is high on beat 6.
- Backpressure: during GNT_B toggle out_ready 1,0,1,0 → b_ready tracks out_ready each cycle, beat_cnt advances only on transfers, and data holds stable.
- Stall: A drops a_valid mid-burst for 3 cycles while b_valid=1 → grant stays on A, out_valid=0, and B gets no ready until A's last beat.
- Mid-burst reset: assert rst after beat 2 of a 4-beat B burst → next cycle is IDLE with sin=0 and ptr=1; the following arbitration with both valid grants A.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 2:1 mux arbiter.
//   state_t : arbiter state encoding (IDLE / GNT_A / GNT_B)
//   SEL_A   : mux select value that routes source A to the output
//   SEL_B   : mux select value that routes source B to the output
//   sel_of  : select value the mux must carry while in a given state
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    // Only GNT_A routes A; IDLE parks the select on B.
    function automatic logic sel_of(input state_t st);
        logic sel;
        if (st == GNT_A) begin
            sel = SEL_A;
        end else begin
            sel = SEL_B;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mux2.sv
// Combinational WIDTH-bit 2:1 select, bitwise and-or form.
//   a   : input selected when sin = 1
//   b   : input selected when sin = 0
//   sin : select
//   f   : (sin & a) | (~sin & b)
module mux2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sin,
    output logic [WIDTH-1:0] f
);

    assign f = ({WIDTH{sin}} & a) | ({WIDTH{~sin}} & b);

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter / sequencer driving the select of a shared 2:1 mux.
// The winning source owns the output for a whole burst; bursts are capped
// at MAX_BEATS beats, after which out_last is forced.
//   clk, rst                   : clock, synchronous active-high reset
//   a_data/a_valid/a_last      : source A beat, a_ready accepts it
//   b_data/b_valid/b_last      : source B beat, b_ready accepts it
//   out_data/out_valid/out_last: muxed beat to downstream, out_ready accepts
//   sin                        : registered mux select (1 = A, 0 = B)
//   busy                       : a grant is active
module mux2_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    input  logic             a_last,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    input  logic             b_last,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sin,
    output logic             busy
);

    import mux_arb_pkg::*;

    localparam int              CNT_W    = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           next_state_s;
    logic             ptr_r;        // 1: A favoured on a tie, 0: B favoured
    logic [CNT_W-1:0] beat_cnt_r;   // beats transferred in the current grant
    logic             sin_r;
    logic             busy_r;
    logic             limit_s;
    logic             xfer_s;
    logic             burst_end_s;

    assign limit_s     = (beat_cnt_r == LAST_CNT);
    assign xfer_s      = out_valid & out_ready;
    // A forced end from the limit counts exactly like a source last.
    assign burst_end_s = xfer_s & out_last;

    // State, pointer, beat counter and registered select/busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            sin_r      <= SEL_B;
            busy_r     <= 1'b0;
            ptr_r      <= 1'b1;
            beat_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            // Select follows the next state so it only moves on an edge.
            sin_r   <= sel_of(next_state_s);
            busy_r  <= (next_state_s != IDLE);
            // After a burst, favour whoever did not just finish.
            if (burst_end_s) begin
                ptr_r <= (state_r == GNT_A) ? 1'b0 : 1'b1;
            end else begin
                ptr_r <= ptr_r;
            end
            // Every burst end starts a fresh grant (even a re-grant).
            if (burst_end_s || (next_state_s == IDLE)) begin
                beat_cnt_r <= {CNT_W{1'b0}};
            end else if (xfer_s) begin
                beat_cnt_r <= beat_cnt_r + CNT_ONE;
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
        end
    end

    // Next-state: arbitration from IDLE and hand-over at burst end.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (a_valid && b_valid) begin
                    next_state_s = ptr_r ? GNT_A : GNT_B;
                end else if (a_valid) begin
                    next_state_s = GNT_A;
                end else if (b_valid) begin
                    next_state_s = GNT_B;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GNT_A: begin
                if (burst_end_s) begin
                    if (b_valid) begin
                        next_state_s = GNT_B;
                    end else if (a_valid) begin
                        next_state_s = GNT_A;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = GNT_A;
                end
            end
            GNT_B: begin
                if (burst_end_s) begin
                    if (a_valid) begin
                        next_state_s = GNT_A;
                    end else if (b_valid) begin
                        next_state_s = GNT_B;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = GNT_B;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Handshake outputs; ready depends only on out_ready, never on valid.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        case (state_r)
            IDLE: begin
                out_valid = 1'b0;
                out_last  = 1'b0;
            end
            GNT_A: begin
                out_valid = a_valid;
                out_last  = a_last | limit_s;
                a_ready   = out_ready;
                b_ready   = 1'b0;
            end
            GNT_B: begin
                out_valid = b_valid;
                out_last  = b_last | limit_s;
                a_ready   = 1'b0;
                b_ready   = out_ready;
            end
            default: begin
                out_valid = 1'b0;
                out_last  = 1'b0;
            end
        endcase
    end

    assign sin  = sin_r;
    assign busy = busy_r;

    mux2 #(
        .WIDTH (WIDTH)
    ) u_mux2 (
        .a   (a_data),
        .b   (b_data),
        .sin (sin_r),
        .f   (out_data)
    );

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter (WIDTH=8, MAX_BEATS=4).
// Directed vector table, hand-written corner sequences, then random
// stimulus against a burst-level reference model.
module tb_mux2_arbiter;

    localparam int W  = 8;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_data, b_data, out_data;
    logic         a_valid, a_last, a_ready;
    logic         b_valid, b_last, b_ready;
    logic         out_valid, out_last, out_ready;
    logic         sin, busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the port, beats moved in this grant, favour.
    int   m_owner = 0;    // 0 none, 1 A, 2 B
    int   m_beats = 0;
    logic m_fav_a = 1'b1;

    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst(rst),
        .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .sin(sin), .busy(busy)
    );

    typedef struct {
        logic         chk;
        logic         rst;
        logic         av;
        logic         al;
        logic [W-1:0] ad;
        logic         bv;
        logic         bl;
        logic [W-1:0] bd;
        logic         rdy;
        logic         e_sin;
        logic         e_busy;
        logic         e_ov;
        logic         e_ol;
        logic         e_ar;
        logic         e_br;
        logic [W-1:0] e_od;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic al, input logic [W-1:0] ad,
                         input logic bv, input logic bl, input logic [W-1:0] bd, input logic rdy);
        rst = r; a_valid = av; a_last = al; a_data = ad;
        b_valid = bv; b_last = bl; b_data = bd; out_ready = rdy;
    endtask

    // Compare all outputs against the model, then advance one clock.
    task automatic tick(input logic do_chk);
        logic         own_a, own_b, e_ov, e_ol;
        logic [W-1:0] e_od;
        logic         mine_v, mine_l, other_v;
        #1;
        own_a = (m_owner == 1);
        own_b = (m_owner == 2);
        e_ov  = own_a ? a_valid : (own_b ? b_valid : 1'b0);
        e_ol  = own_a ? (a_last | (m_beats == MB - 1)) :
                own_b ? (b_last | (m_beats == MB - 1)) : 1'b0;
        e_od  = own_a ? a_data : b_data;
        if (do_chk) begin
            check("m_sin",       32'(sin),       32'(own_a));
            check("m_busy",      32'(busy),      32'(own_a | own_b));
            check("m_out_valid", 32'(out_valid), 32'(e_ov));
            check("m_out_last",  32'(out_last),  32'(e_ol));
            check("m_a_ready",   32'(a_ready),   32'(own_a & out_ready));
            check("m_b_ready",   32'(b_ready),   32'(own_b & out_ready));
            check("m_out_data",  32'(out_data),  32'(e_od));
        end
        @(posedge clk);
        if (rst) begin
            m_owner = 0; m_beats = 0; m_fav_a = 1'b1;
        end else if (m_owner == 0) begin
            if (a_valid && b_valid) m_owner = m_fav_a ? 1 : 2;
            else if (a_valid)       m_owner = 1;
            else if (b_valid)       m_owner = 2;
        end else begin
            mine_v  = own_a ? a_valid : b_valid;
            mine_l  = own_a ? a_last  : b_last;
            other_v = own_a ? b_valid : a_valid;
            if (mine_v && out_ready) begin
                if (mine_l || m_beats == MB - 1) begin
                    m_fav_a = (m_owner == 2);
                    m_beats = 0;
                    if (other_v)     m_owner = 3 - m_owner;
                    else if (!mine_v) m_owner = 0;
                end else begin
                    m_beats++;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // {chk, rst, av, al, ad, bv, bl, bd, rdy | sin, busy, ov, ol, ar, br, od}
        vecs[0]  = '{1'b0,1'b1, 1'b1,1'b0,8'hA0, 1'b1,1'b0,8'hB0, 1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'hB0};
        vecs[1]  = '{1'b1,1'b1, 1'b1,1'b0,8'hA0, 1'b1,1'b0,8'hB0, 1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'hB0};
        vecs[2]  = '{1'b1,1'b0, 1'b1,1'b0,8'hA0, 1'b1,1'b0,8'hB0, 1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'hB0};
        vecs[3]  = '{1'b1,1'b0, 1'b1,1'b0,8'hA0, 1'b1,1'b0,8'hB0, 1'b1, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,8'hA0};
        vecs[4]  = '{1'b1,1'b0, 1'b1,1'b0,8'hA1, 1'b1,1'b0,8'hB0, 1'b1, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,8'hA1};
        vecs[5]  = '{1'b1,1'b0, 1'b1,1'b1,8'hA2, 1'b1,1'b0,8'hB0, 1'b1, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,8'hA2};
        vecs[6]  = '{1'b1,1'b0, 1'b1,1'b0,8'hA0, 1'b1,1'b0,8'hB0, 1'b1, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,8'hB0};
        vecs[7]  = '{1'b1,1'b0, 1'b1,1'b0,8'hA0, 1'b1,1'b0,8'hB1, 1'b1, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,8'hB1};
        vecs[8]  = '{1'b1,1'b0, 1'b1,1'b0,8'hA0, 1'b1,1'b1,8'hB2, 1'b1, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,8'hB2};
        vecs[9]  = '{1'b1,1'b0, 1'b1,1'b0,8'h10, 1'b0,1'b0,8'hB0, 1'b1, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,8'h10};
        vecs[10] = '{1'b1,1'b0, 1'b1,1'b0,8'h11, 1'b0,1'b0,8'hB0, 1'b1, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,8'h11};
        vecs[11] = '{1'b1,1'b0, 1'b1,1'b0,8'h12, 1'b0,1'b0,8'hB0, 1'b1, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,8'h12};
        vecs[12] = '{1'b1,1'b0, 1'b1,1'b0,8'h13, 1'b0,1'b0,8'hB0, 1'b1, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,8'h13};
        vecs[13] = '{1'b1,1'b0, 1'b1,1'b0,8'h14, 1'b0,1'b0,8'hB0, 1'b1, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,8'h14};
        vecs[14] = '{1'b1,1'b0, 1'b1,1'b1,8'h15, 1'b0,1'b0,8'hB0, 1'b1, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,8'h15};

        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);

        // Reset, alternation and beat-limit vectors.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].al, vecs[i].ad,
                  vecs[i].bv, vecs[i].bl, vecs[i].bd, vecs[i].rdy);
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d_sin", i),       32'(sin),       32'(vecs[i].e_sin));
                check($sformatf("v%0d_busy", i),      32'(busy),      32'(vecs[i].e_busy));
                check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
                check($sformatf("v%0d_out_last", i),  32'(out_last),  32'(vecs[i].e_ol));
                check($sformatf("v%0d_a_ready", i),   32'(a_ready),   32'(vecs[i].e_ar));
                check($sformatf("v%0d_b_ready", i),   32'(b_ready),   32'(vecs[i].e_br));
                check($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].e_od));
            end
            tick(vecs[i].chk);
        end

        // Backpressure during a B grant: ready tracks out_ready, data holds.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        tick(1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC0, 1'b1);
        tick(1'b1);
        begin
            int k;
            k = 0;
            for (int i = 0; i < 10 && k < 4; i++) begin
                logic rdy;
                rdy = (i % 2 == 0);
                drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, (k == 3), 8'hC0 + 8'(k), rdy);
                #1;
                check("bp_b_ready", 32'(b_ready), 32'(rdy));
                check("bp_data",    32'(out_data), 32'(8'hC0 + 8'(k)));
                check("bp_last",    32'(out_last), 32'(k == 3));
                tick(1'b1);
                if (rdy) k++;
            end
            check("bp_done", 32'(k), 32'(4));
        end

        // Stall: A drops valid mid-burst while B waits.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        tick(1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'hD0, 1'b1, 1'b0, 8'hE0, 1'b1);
        tick(1'b1);
        tick(1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'hD1, 1'b1, 1'b0, 8'hE0, 1'b1);
        tick(1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'hD2, 1'b1, 1'b0, 8'hE0, 1'b1);
            #1;
            check("stall_sin",       32'(sin),       32'(1'b1));
            check("stall_out_valid", 32'(out_valid), 32'(1'b0));
            check("stall_b_ready",   32'(b_ready),   32'(1'b0));
            tick(1'b1);
        end
        drive(1'b0, 1'b1, 1'b0, 8'hD2, 1'b1, 1'b0, 8'hE0, 1'b1);
        tick(1'b1);
        drive(1'b0, 1'b1, 1'b1, 8'hD3, 1'b1, 1'b0, 8'hE0, 1'b1);
        #1;
        check("stall_last_beat", 32'(out_last), 32'(1'b1));
        check("stall_b_wait",    32'(b_ready),  32'(1'b0));
        tick(1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'hD4, 1'b1, 1'b0, 8'hE0, 1'b1);
        #1;
        check("stall_handover", 32'(sin), 32'(1'b0));
        check("stall_b_grant",  32'(b_ready), 32'(1'b1));
        tick(1'b1);

        // Mid-burst reset during a 4-beat B burst.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        tick(1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hF0, 1'b1);
        tick(1'b1);
        tick(1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hF1, 1'b1);
        tick(1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hF2, 1'b1);
        tick(1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'hF2, 1'b1);
        #1;
        check("mrst_sin",  32'(sin),  32'(1'b0));
        check("mrst_busy", 32'(busy), 32'(1'b0));
        check("mrst_ovld", 32'(out_valid), 32'(1'b0));
        tick(1'b1);
        #1;
        check("mrst_grant_a", 32'(sin), 32'(1'b1));
        tick(1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 8'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 8'($urandom),
                  ($urandom_range(0, 3) != 0));
            tick(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
